hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the five-stage core. Watches decode-stage source registers, the execute-stage load destination, taken branches and the instruction/data memory handshakes. Drives the per-stage stall and flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC. Tracks outstanding fetches so that wrong-path instruction responses are squashed, and keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the five-stage core.
// Latency: stall/flush/squash outputs are combinational from state and current inputs; counters update at posedge.
// Backpressure: a data-memory wait freezes every stage, a load-use hazard or an outstanding fetch holds the front end.
//
// Ports:
//   clk, rst                  pipeline clock, asynchronous active-high reset
//   rs1_d/rs2_d, *_use_d      decode-stage source registers and whether they are read
//   rd_e, load_e, br_taken_e  execute-stage destination, load flag, redirect request
//   imem_req_f, imem_resp     instruction-memory request/response pulses
//   dmem_req_m, dmem_resp     data-memory request/completion pulses
//   stall_*, flush_*, bubble_w, squash_f   per-stage pipeline controls
//   stall_cnt, flush_cnt      saturating performance counters
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic             rs1_use_d,
  input  logic             rs2_use_d,
  input  logic [4:0]       rd_e,
  input  logic             load_e,
  input  logic             br_taken_e,
  input  logic             imem_req_f,
  input  logic             imem_resp,
  input  logic             dmem_req_m,
  input  logic             dmem_resp,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             bubble_w,
  output logic             squash_f,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, DWAIT} state_t;

  state_t state, state_nxt;
  logic   fout, fout_nxt;   // an instruction fetch is in flight
  logic   sq, sq_nxt;       // the in-flight fetch is wrong-path and must be dropped

  logic dwait, luse, br, iwait;

  // The data wait starts in the request cycle itself, so the whole pipe
  // freezes without needing a cycle to enter DWAIT first.
  assign dwait = ((state == DWAIT) || dmem_req_m) && !dmem_resp;

  assign luse = load_e && (rd_e != 5'd0) &&
                ((rs1_use_d && (rs1_d == rd_e)) || (rs2_use_d && (rs2_d == rd_e)));

  // A redirect cannot be taken while EX is frozen; br_taken_e is held
  // stable, so it is acted on in the cycle the data wait ends.
  assign br = br_taken_e && !dwait;

  // A squashed response does not satisfy the fetch wait.
  logic squash_raw;
  assign squash_raw = imem_resp && (sq || br);
  assign iwait      = fout && (!imem_resp || squash_raw);

  // State register and flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      fout  <= 1'b0;
      sq    <= 1'b0;
    end else begin
      state <= state_nxt;
      fout  <= fout_nxt;
      sq    <= sq_nxt;
    end
  end

  // Next state and pipeline controls
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (dmem_req_m && !dmem_resp) state_nxt = DWAIT;
      DWAIT:   if (dmem_resp)                state_nxt = RUN;
      default: state_nxt = RUN;
    endcase

    // A new request always wins over a response in the same cycle: the
    // response belongs to the older fetch, the new one is still pending.
    fout_nxt = fout;
    if (imem_req_f)     fout_nxt = 1'b1;
    else if (imem_resp) fout_nxt = 1'b0;

    // A redirect coinciding with the response squashes it directly, so
    // there is nothing left to remember.
    sq_nxt = sq;
    if (imem_resp)      sq_nxt = 1'b0;
    else if (br && fout) sq_nxt = 1'b1;

    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    bubble_w = 1'b0;
    squash_f = 1'b0;

    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      squash_f = squash_raw;
      if (dwait) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        stall_m  = 1'b1;
        bubble_w = 1'b1;
      end else if (br) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (luse) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if (iwait) begin
        stall_f = 1'b1;
        flush_d = 1'b1;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (br && (flush_cnt != '1))      flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with hand-computed expectations.
// Control outputs are checked mid-cycle; counters after the edge.
// A second narrow-counter instance checks saturation.
module tb_hazard_ctrl;

  logic       clk, rst;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic       rs1_use_d, rs2_use_d, load_e, br_taken_e;
  logic       imem_req_f, imem_resp, dmem_req_m, dmem_resp;

  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w, squash_f;
  logic [31:0] stall_cnt, flush_cnt;

  logic        s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_flush_d, s_flush_e, s_bubble_w, s_squash_f;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_use_d(rs1_use_d), .rs2_use_d(rs2_use_d),
    .rd_e(rd_e), .load_e(load_e), .br_taken_e(br_taken_e),
    .imem_req_f(imem_req_f), .imem_resp(imem_resp),
    .dmem_req_m(dmem_req_m), .dmem_resp(dmem_resp),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .bubble_w(bubble_w), .squash_f(squash_f),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_use_d(rs1_use_d), .rs2_use_d(rs2_use_d),
    .rd_e(rd_e), .load_e(load_e), .br_taken_e(br_taken_e),
    .imem_req_f(imem_req_f), .imem_resp(imem_resp),
    .dmem_req_m(dmem_req_m), .dmem_resp(dmem_resp),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e), .stall_m(s_stall_m),
    .flush_d(s_flush_d), .flush_e(s_flush_e), .bubble_w(s_bubble_w), .squash_f(s_squash_f),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control vector: {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,bubble_w,squash_f}
  logic [7:0] ctl;
  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w, squash_f};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rd_e = 0;
    rs1_use_d = 0; rs2_use_d = 0; load_e = 0; br_taken_e = 0;
    imem_req_f = 0; imem_resp = 0; dmem_req_m = 0; dmem_resp = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs mid-cycle before checking.
  task automatic settle();
    #2;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_ctl",   {24'd0, ctl}, 32'h0C);
    check("rst_scnt",  stall_cnt, 0);
    check("rst_fcnt",  flush_cnt, 0);
    @(posedge clk);
    step();
    rst = 1'b0;
    settle();
    check("idle_ctl", {24'd0, ctl}, 32'h00);

    // Load-use on rs1
    step();
    load_e = 1; rd_e = 5; rs1_d = 5; rs1_use_d = 1;
    settle();
    check("luse_rs1", {24'd0, ctl}, 32'hC4);
    step();
    idle();
    settle();
    check("luse_done", {24'd0, ctl}, 32'h00);
    check("luse_scnt", stall_cnt, 1);

    // rd_e = 0 never hazards
    load_e = 1; rd_e = 0; rs1_d = 0; rs1_use_d = 1;
    settle();
    check("luse_x0", {24'd0, ctl}, 32'h00);

    // Load-use on rs2; then same match with rs2 unused
    step();
    idle();
    load_e = 1; rd_e = 7; rs2_d = 7; rs2_use_d = 1;
    settle();
    check("luse_rs2", {24'd0, ctl}, 32'hC4);
    step();
    rs2_use_d = 0;
    settle();
    check("luse_unused", {24'd0, ctl}, 32'h00);
    check("luse_scnt2", stall_cnt, 2);

    // Data wait: request then three waiting cycles, response on the fifth
    step();
    idle();
    dmem_req_m = 1;
    settle();
    check("dwait_req", {24'd0, ctl}, 32'hF2);
    for (int i = 0; i < 3; i++) begin
      step();
      dmem_req_m = 0;
      settle();
      check("dwait_hold", {24'd0, ctl}, 32'hF2);
    end
    step();
    dmem_resp = 1;
    settle();
    check("dwait_resp", {24'd0, ctl}, 32'h00);
    step();
    idle();
    settle();
    check("dwait_run", {24'd0, ctl}, 32'h00);
    check("dwait_scnt", stall_cnt, 6);

    // Branch while a fetch is outstanding
    imem_req_f = 1;
    settle();
    check("br_req", {24'd0, ctl}, 32'h00);
    step();
    imem_req_f = 0; br_taken_e = 1;
    settle();
    check("br_flush", {24'd0, ctl}, 32'h0C);
    step();
    br_taken_e = 0;
    settle();
    check("br_iwait", {24'd0, ctl}, 32'h88);
    check("br_fcnt", flush_cnt, 1);
    step();
    imem_resp = 1;
    settle();
    check("br_squash", {24'd0, ctl}, 32'h89);
    step();
    imem_resp = 0;
    settle();
    check("br_after", {24'd0, ctl}, 32'h00);
    check("br_scnt", stall_cnt, 8);
    // Stray response with nothing outstanding passes through
    imem_resp = 1;
    settle();
    check("stray_resp", {24'd0, ctl}, 32'h00);

    // Branch held through a data wait
    step();
    idle();
    dmem_req_m = 1; br_taken_e = 1;
    settle();
    check("brd_wait0", {24'd0, ctl}, 32'hF2);
    step();
    dmem_req_m = 0;
    settle();
    check("brd_wait1", {24'd0, ctl}, 32'hF2);
    check("brd_fcnt0", flush_cnt, 1);
    step();
    dmem_resp = 1;
    settle();
    check("brd_resp", {24'd0, ctl}, 32'h0C);
    step();
    idle();
    settle();
    check("brd_after", {24'd0, ctl}, 32'h00);
    check("brd_fcnt1", flush_cnt, 2);
    check("brd_scnt", stall_cnt, 10);

    // Fetch wait and load-use together: load-use wins
    imem_req_f = 1;
    step();
    imem_req_f = 0;
    load_e = 1; rd_e = 9; rs1_d = 9; rs1_use_d = 1;
    settle();
    check("iw_luse", {24'd0, ctl}, 32'hC4);
    step();
    idle();
    settle();
    check("iw_only", {24'd0, ctl}, 32'h88);
    step();
    imem_resp = 1;
    settle();
    check("iw_resp", {24'd0, ctl}, 32'h00);
    step();
    idle();
    settle();
    check("iw_scnt", stall_cnt, 12);
    check("sat_scnt", {29'd0, s_stall_cnt}, 7);
    check("sat_fcnt", {29'd0, s_flush_cnt}, 2);

    // Asynchronous reset in the middle of a data wait
    dmem_req_m = 1;
    step();
    dmem_req_m = 0;
    settle();
    check("ar_dwait", {24'd0, ctl}, 32'hF2);
    #1 rst = 1'b1;
    #1;
    check("ar_ctl", {24'd0, ctl}, 32'h0C);
    check("ar_scnt", stall_cnt, 0);
    check("ar_fcnt", flush_cnt, 0);
    step();
    rst = 1'b0;
    settle();
    check("ar_run", {24'd0, ctl}, 32'h00);
    step();
    settle();
    check("ar_run2", {24'd0, ctl}, 32'h00);
    check("ar_scnt2", stall_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
